// File: rtl/rotate_pkg.sv
// Shared constants for the round-robin rotate arbiter.
package rotate_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/rotate16_core.sv
// Combinational 16-bit rotator, left or right by 0-15.
module rotate16_core
  import rotate_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [AMT_W-1:0]  s_i,
  input  logic              dir_i,
  output logic [DATA_W-1:0] y_o
);
  logic [AMT_W-1:0] src;

  // 4-bit index arithmetic wraps modulo 16 for free
  always_comb begin
    y_o = '0;
    src = '0;
    for (int k = 0; k < DATA_W; k++) begin
      if (dir_i == DIR_LEFT) src = AMT_W'(k) - s_i;
      else                   src = AMT_W'(k) + s_i;
      y_o[k] = a_i[src];
    end
  end
endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin shared rotator feeding a 2-entry tagged result FIFO.
module rotate_arbiter
  import rotate_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [DATA_W*NREQ-1:0]   req_data,
  input  logic [AMT_W*NREQ-1:0]    req_amt,
  input  logic [NREQ-1:0]          req_dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDW-1:0]           out_id,
  output logic [1:0]               cnt
);
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    gidx;
  logic              found;
  logic              space;
  logic              push, pop, wsel;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] dat_q [2];
  logic [DATA_W-1:0] dat_d [2];
  logic [IDW-1:0]    id_q  [2];
  logic [IDW-1:0]    id_d  [2];
  logic [DATA_W-1:0] rot;
  logic [DATA_W-1:0] opa;
  logic [AMT_W-1:0]  opamt;
  logic              opdir;

  // a full FIFO still has room if the head leaves this cycle
  assign space = (cnt_q != 2'd2) | out_ready;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gidx  = IDW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && space && found) req_ready[gidx] = 1'b1;
  end

  assign push  = |req_ready;
  assign pop   = (cnt_q != 2'd0) & out_ready;
  assign opa   = req_data[gidx*DATA_W +: DATA_W];
  assign opamt = req_amt[gidx*AMT_W +: AMT_W];
  assign opdir = req_dir[gidx];

  rotate16_core u_rot (
    .a_i   (opa),
    .s_i   (opamt),
    .dir_i (opdir),
    .y_o   (rot)
  );

  assign wsel = pop ? (cnt_q == 2'd2) : (cnt_q == 2'd1);

  always_comb begin
    dat_d = dat_q;
    id_d  = id_q;
    if (pop) begin
      dat_d[0] = dat_q[1];
      id_d[0]  = id_q[1];
    end
    if (push) begin
      dat_d[wsel] = rot;
      id_d[wsel]  = gidx;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      if (gidx == IDW'(NREQ - 1)) ptr_d = '0;
      else                        ptr_d = gidx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      cnt_q    <= '0;
      dat_q[0] <= '0;
      dat_q[1] <= '0;
      id_q[0]  <= '0;
      id_q[1]  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      dat_q[0] <= dat_d[0];
      dat_q[1] <= dat_d[1];
      id_q[0]  <= id_d[0];
      id_q[1]  <= id_d[1];
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = dat_q[0];
  assign out_id    = id_q[0];
  assign cnt       = cnt_q;
endmodule
